// File: rtl/data_mem_responder.sv
// Data-memory slave for the core load/store port: one request at a time, fixed wait
// states, byte-enabled writes, full-word reads, one-cycle ready pulse on completion.

module data_mem_lane #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          wr,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  // Contents are deliberately not reset.
  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk)
    if (wr) mem[idx] <= wdata;

  assign rdata = mem[idx];
endmodule

module data_mem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        data_ready_o,
  output logic        data_err_o
);
  localparam int unsigned NUM_LANES = 4;
  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  state_e                      state_q, state_d;
  logic [3:0]                  cnt_q, cnt_d;
  req_t                        lat_q, lat_d;
  logic [31:0]                 offset;
  logic                        in_range;
  logic [AW-1:0]               idx;
  logic                        enter_resp;
  logic [NUM_LANES-1:0][7:0]   rd_word;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    case (state_q)
      IDLE: if (data_req_i) begin
        lat_d   = '{we: data_we_i, be: data_be_i, addr: data_addr_i, wdata: data_wdata_i};
        cnt_d   = 4'(WAIT_CYCLES);
        state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Decode from lat_d so a zero-wait request is served from the live inputs
  // on the same edge that accepts it.
  assign offset     = lat_d.addr - BASE_ADDR;
  assign in_range   = offset < SPAN;
  assign idx        = offset[AW+1:2];
  assign enter_resp = (state_d == RESP);

  genvar n;
  for (n = 0; n < NUM_LANES; n++) begin : g_lane
    data_mem_lane #(.DEPTH(DEPTH_WORDS), .AW(AW)) u_lane (
      .clk   (clk_i),
      .wr    (enter_resp && lat_d.we && lat_d.be[n] && in_range),
      .idx   (idx),
      .wdata (lat_d.wdata[8*n +: 8]),
      .rdata (rd_word[n])
    );
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      lat_q        <= '0;
      data_ready_o <= 1'b0;
      data_err_o   <= 1'b0;
      data_rdata_o <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_q        <= lat_d;
      data_ready_o <= enter_resp;
      data_err_o   <= enter_resp && !in_range;
      if (enter_resp && !lat_d.we)
        data_rdata_o <= in_range ? rd_word : 32'h0;
    end
  end
endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: five instances covering the wait-state and
// depth corners, each feature exercised by its own task with hand-computed results.

module tb_data_mem_responder;
  localparam int N = 5;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [N-1:0]        req;
  logic                we;
  logic [3:0]          be;
  logic [31:0]         addr, wdata;
  logic [N-1:0][31:0]  rdata;
  logic [N-1:0]        ready, err;
  int                  errors = 0;
  int                  checks = 0;

  always #5 clk = ~clk;

  // 0: W=1 D=1024   1: W=0 D=16 base 0x1000   2: W=7 D=1024   3: W=15 D=16   4: W=3 D=1024
  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(1)) u_d0 (
    .clk_i(clk), .arstn_i(rst_n), .data_req_i(req[0]), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_rdata_o(rdata[0]),
    .data_ready_o(ready[0]), .data_err_o(err[0]));
  data_mem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h1000), .WAIT_CYCLES(0)) u_d1 (
    .clk_i(clk), .arstn_i(rst_n), .data_req_i(req[1]), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_rdata_o(rdata[1]),
    .data_ready_o(ready[1]), .data_err_o(err[1]));
  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(7)) u_d2 (
    .clk_i(clk), .arstn_i(rst_n), .data_req_i(req[2]), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_rdata_o(rdata[2]),
    .data_ready_o(ready[2]), .data_err_o(err[2]));
  data_mem_responder #(.DEPTH_WORDS(16), .BASE_ADDR(32'h0), .WAIT_CYCLES(15)) u_d3 (
    .clk_i(clk), .arstn_i(rst_n), .data_req_i(req[3]), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_rdata_o(rdata[3]),
    .data_ready_o(ready[3]), .data_err_o(err[3]));
  data_mem_responder #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0), .WAIT_CYCLES(3)) u_d4 (
    .clk_i(clk), .arstn_i(rst_n), .data_req_i(req[4]), .data_we_i(we), .data_be_i(be),
    .data_addr_i(addr), .data_wdata_i(wdata), .data_rdata_o(rdata[4]),
    .data_ready_o(ready[4]), .data_err_o(err[4]));

  // One transaction on instance d; lat counts negedges after the accept edge until ready.
  task automatic xfer(input int d, input logic w, input logic [3:0] b, input logic [31:0] a,
                      input logic [31:0] wd, output logic [31:0] rd, output logic e,
                      output int lat);
    @(negedge clk);
    we = w; be = b; addr = a; wdata = wd; req[d] = 1'b1;
    @(posedge clk);
    lat = -1; rd = 32'hxxxx_xxxx; e = 1'bx;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (ready[d]) begin
        lat = n; rd = rdata[d]; e = err[d];
        break;
      end
    end
    req[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '0; we = 1'b0; be = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    checks++; if (ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0", ready); end
    checks++; if (err !== '0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (rdata[0] !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata[0]); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [31:0] rd; logic e; int lat;
    xfer(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, rd, e, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL basic_wr_lat: got %0d want 2", lat); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_wr_err: got %b want 0", e); end
    xfer(0, 1'b0, 4'h0, 32'h10, 32'h0, rd, e, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL basic_rd_lat: got %0d want 2", lat); end
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data: got %h want deadbeef", rd); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL basic_rd_err: got %b want 0", e); end
    @(negedge clk);
    checks++; if (ready[0] !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got %b want 0", ready[0]); end
  endtask

  task automatic test_partial();
    logic [31:0] rd; logic e; int lat;
    xfer(0, 1'b1, 4'hF, 32'h20, 32'h11223344, rd, e, lat);
    xfer(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, rd, e, lat);
    xfer(0, 1'b0, 4'h0, 32'h20, 32'h0, rd, e, lat);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL partial_data: got %h want 11bb33dd", rd); end
    xfer(0, 1'b1, 4'b0000, 32'h20, 32'hFFFFFFFF, rd, e, lat);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL be0_err: got %b want 0", e); end
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL wr_keeps_rdata: got %h want 11bb33dd", rd); end
    xfer(0, 1'b0, 4'h0, 32'h20, 32'h0, rd, e, lat);
    checks++; if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL be0_nochange: got %h want 11bb33dd", rd); end
  endtask

  task automatic test_addr_decode();
    logic [31:0] rd; logic e; int lat;
    xfer(0, 1'b0, 4'h0, 32'h13, 32'h0, rd, e, lat);
    checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL misaligned: got %h want deadbeef", rd); end
    xfer(0, 1'b0, 4'h0, 32'h1000, 32'h0, rd, e, lat);
    checks++; if (rd !== 32'h0) begin errors++; $display("FAIL oor_rd_data: got %h want 0", rd); end
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL oor_rd_err: got %b want 1", e); end
    checks++; if (lat !== 2) begin errors++; $display("FAIL oor_rd_lat: got %0d want 2", lat); end
    xfer(0, 1'b1, 4'hF, 32'hFFC, 32'h01020304, rd, e, lat);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL last_word_err: got %b want 0", e); end
    // BASE-4 wraps to an offset whose index bits alias the last word
    xfer(0, 1'b1, 4'hF, 32'hFFFFFFFC, 32'hCAFEF00D, rd, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL below_base_err: got %b want 1", e); end
    xfer(0, 1'b0, 4'h0, 32'hFFC, 32'h0, rd, e, lat);
    checks++; if (rd !== 32'h01020304) begin errors++; $display("FAIL below_base_nowrite: got %h want 01020304", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic e; int lat; int k;
    logic        ow [5];
    logic [31:0] oa [5];
    logic [31:0] od [5];
    logic [31:0] ex [5];
    ow[0] = 1'b0; oa[0] = 32'h1000; od[0] = 32'h0;        ex[0] = 32'h0000AAAA;
    ow[1] = 1'b1; oa[1] = 32'h1008; od[1] = 32'h12345678; ex[1] = 32'h0000AAAA;
    ow[2] = 1'b0; oa[2] = 32'h1004; od[2] = 32'h0;        ex[2] = 32'h0000BBBB;
    ow[3] = 1'b0; oa[3] = 32'h1008; od[3] = 32'h0;        ex[3] = 32'h12345678;
    ow[4] = 1'b1; oa[4] = 32'h100C; od[4] = 32'h9;        ex[4] = 32'h12345678;
    xfer(1, 1'b1, 4'hF, 32'h1000, 32'h0000AAAA, rd, e, lat);
    checks++; if (lat !== 1) begin errors++; $display("FAIL w0_lat: got %0d want 1", lat); end
    xfer(1, 1'b1, 4'hF, 32'h1004, 32'h0000BBBB, rd, e, lat);
    @(negedge clk);
    k = 0;
    we = ow[0]; be = 4'hF; addr = oa[0]; wdata = od[0]; req[1] = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      checks++;
      if (ready[1] !== 1'(c % 2)) begin
        errors++; $display("FAIL b2b_ready_c%0d: got %b want %b", c, ready[1], 1'(c % 2));
      end
      if (ready[1] && k < 5) begin
        checks++;
        if (rdata[1] !== ex[k]) begin errors++; $display("FAIL b2b_rdata_op%0d: got %h want %h", k, rdata[1], ex[k]); end
        k++;
        if (k < 5) begin we = ow[k]; addr = oa[k]; wdata = od[k]; end
        else req[1] = 1'b0;
      end else if (k > 0) begin
        checks++;
        if (rdata[1] !== ex[k-1]) begin errors++; $display("FAIL b2b_hold_c%0d: got %h want %h", c, rdata[1], ex[k-1]); end
      end
    end
    req[1] = 1'b0;
    checks++; if (k !== 5) begin errors++; $display("FAIL b2b_count: got %0d want 5", k); end
  endtask

  task automatic test_sweep();
    logic [31:0] rd; logic e; int lat;
    xfer(1, 1'b0, 4'h0, 32'h103C, 32'h0, rd, e, lat);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL d16_last_err: got %b want 0", e); end
    xfer(1, 1'b0, 4'h0, 32'h1040, 32'h0, rd, e, lat);
    checks++; if (e !== 1'b1 || rd !== 32'h0) begin errors++; $display("FAIL d16_end: got err=%b rd=%h want err=1 rd=0", e, rd); end
    xfer(1, 1'b0, 4'h0, 32'h0FFC, 32'h0, rd, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL d16_below: got %b want 1", e); end
    xfer(2, 1'b1, 4'hF, 32'h100, 32'h77777777, rd, e, lat);
    checks++; if (lat !== 8) begin errors++; $display("FAIL w7_wr_lat: got %0d want 8", lat); end
    xfer(2, 1'b0, 4'h0, 32'h100, 32'h0, rd, e, lat);
    checks++; if (lat !== 8 || rd !== 32'h77777777) begin errors++; $display("FAIL w7_rd: got lat=%0d rd=%h want 8 77777777", lat, rd); end
    xfer(2, 1'b0, 4'h0, 32'h1000, 32'h0, rd, e, lat);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL w7_end_err: got %b want 1", e); end
    xfer(3, 1'b1, 4'hF, 32'h3C, 32'hF0F0F0F0, rd, e, lat);
    checks++; if (lat !== 16 || e !== 1'b0) begin errors++; $display("FAIL w15_wr: got lat=%0d err=%b want 16 0", lat, e); end
    xfer(3, 1'b0, 4'h0, 32'h3C, 32'h0, rd, e, lat);
    checks++; if (rd !== 32'hF0F0F0F0) begin errors++; $display("FAIL w15_rd: got %h want f0f0f0f0", rd); end
    xfer(3, 1'b0, 4'h0, 32'h40, 32'h0, rd, e, lat);
    checks++; if (e !== 1'b1 || rd !== 32'h0 || lat !== 16) begin errors++; $display("FAIL w15_end: got err=%b rd=%h lat=%0d want 1 0 16", e, rd, lat); end
  endtask

  task automatic test_reset_mid_write();
    logic [31:0] rd; logic e; int lat; logic saw;
    xfer(4, 1'b1, 4'hF, 32'h40, 32'h0BADF00D, rd, e, lat);
    checks++; if (lat !== 4) begin errors++; $display("FAIL w3_lat: got %0d want 4", lat); end
    xfer(4, 1'b0, 4'h0, 32'h40, 32'h0, rd, e, lat);
    @(negedge clk);
    we = 1'b1; be = 4'hF; addr = 32'h40; wdata = 32'h5A5A5A5A; req[4] = 1'b1;
    @(posedge clk);
    repeat (2) @(negedge clk);
    rst_n = 1'b0; req[4] = 1'b0;
    #1;
    checks++; if (rdata[4] !== 32'h0 || ready[4] !== 1'b0 || err[4] !== 1'b0) begin
      errors++; $display("FAIL rst_mid_outputs: got rd=%h rdy=%b err=%b want 0 0 0", rdata[4], ready[4], err[4]);
    end
    saw = 1'b0;
    repeat (2) begin @(negedge clk); saw |= ready[4]; end
    rst_n = 1'b1;
    repeat (8) begin @(negedge clk); saw |= ready[4]; end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL rst_mid_no_ready: got %b want 0", saw); end
    xfer(4, 1'b0, 4'h0, 32'h40, 32'h0, rd, e, lat);
    checks++; if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL rst_mid_dropped: got %h want 0badf00d", rd); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_partial();
    test_addr_decode();
    test_back_to_back();
    test_sweep();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
